// File: rtl/mod_reduce_seq_pkg.sv
// Shared types and helpers for the sequential divider / modular reducer.
// The FSM encoding is exported so that a debug port can expose it.
package karat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an iteration counter that must be able to hold the value d.
  function automatic int cnt_width(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/mod_reduce_seq_if.sv
// Start/done bus between the multiplier chain and the reducer.
// enable is a start request seen only while idle; o_finish pulses for one cycle and
// the results stay valid until the next accepted start (no back-pressure, no queuing).
interface mod_reduce_seq_if #(
  parameter int input_size    = 1024,
  parameter int dividend_size = 2 * input_size
);
  import karat_pkg::*;

  logic                     enable;
  logic [dividend_size-1:0] dividend;
  logic [input_size-1:0]    divisor;
  logic [dividend_size-1:0] quotient;
  logic [input_size-1:0]    remainder;
  logic                     o_busy;
  logic                     o_finish;
  logic                     o_div_zero;
  state_t                   dbg_state;

  modport master (
    output enable, dividend, divisor,
    input  quotient, remainder, o_busy, o_finish, o_div_zero, dbg_state
  );

  modport slave (
    input  enable, dividend, divisor,
    output quotient, remainder, o_busy, o_finish, o_div_zero, dbg_state
  );

endinterface

// File: rtl/mod_reduce_seq_div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder and
// subtract the divisor when it fits.
module div_step #(
  parameter int input_size = 1024
) (
  input  logic [input_size:0]   pr_in,
  input  logic                  bit_in,
  input  logic [input_size-1:0] divisor,
  output logic [input_size:0]   pr_out,
  output logic                  q_bit
);

  // pr_in < divisor always holds, so its top bit is zero; keeping it in t just
  // makes the compare exact for any input.
  logic [input_size+1:0] w_t;
  logic [input_size+1:0] w_div_ext;

  assign w_t       = {pr_in, bit_in};
  assign w_div_ext = {2'b00, divisor};
  assign q_bit     = (w_t >= w_div_ext);
  assign pr_out    = (input_size + 1)'(q_bit ? (w_t - w_div_ext) : w_t);

endmodule

// File: rtl/mod_reduce_seq.sv
// Fixed-latency radix-2 restoring divider: quotient = dividend / divisor and
// remainder = dividend mod divisor, with a dedicated path for a zero divisor.
module mod_reduce_seq
  import karat_pkg::*;
#(
  parameter int input_size    = 1024,
  parameter int dividend_size = 2 * input_size
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mod_reduce_seq_if.slave       bus
);

  localparam int CW = cnt_width(dividend_size);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [dividend_size-1:0] r_shift;
  logic [dividend_size-1:0] r_quotient;
  logic [input_size:0]      r_pr;
  logic [input_size:0]      w_pr_next;
  logic [input_size-1:0]    r_divisor;
  logic [input_size-1:0]    r_remainder;
  logic [CW-1:0]            r_count;
  logic                     r_div_zero;
  logic                     w_q_bit;
  logic                     w_div_is_zero;
  logic                     w_last_step;

  assign w_div_is_zero = (bus.divisor == '0);
  assign w_last_step   = (r_count == CW'(1));

  div_step #(.input_size(input_size)) u_step (
    .pr_in   (r_pr),
    .bit_in  (r_shift[dividend_size-1]),
    .divisor (r_divisor),
    .pr_out  (w_pr_next),
    .q_bit   (w_q_bit)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (bus.enable) w_next_state = w_div_is_zero ? DONE : RUN;
      RUN:     if (w_last_step) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient: each step shifts one quotient
  // bit in at the bottom while the next dividend bit leaves at the top.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_shift     <= '0;
      r_quotient  <= '0;
      r_pr        <= '0;
      r_divisor   <= '0;
      r_remainder <= '0;
      r_count     <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.enable) begin
            if (w_div_is_zero) begin
              r_div_zero  <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= bus.dividend[input_size-1:0];
            end else begin
              r_shift    <= bus.dividend;
              r_divisor  <= bus.divisor;
              r_pr       <= '0;
              r_count    <= CW'(dividend_size);
              r_div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r_shift <= {r_shift[dividend_size-2:0], w_q_bit};
          r_pr    <= w_pr_next;
          r_count <= r_count - 1'b1;
          if (w_last_step) begin
            r_quotient  <= {r_shift[dividend_size-2:0], w_q_bit};
            r_remainder <= w_pr_next[input_size-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient   = r_quotient;
  assign bus.remainder  = r_remainder;
  assign bus.o_div_zero = r_div_zero;
  assign bus.o_busy     = (r_state != IDLE);
  assign bus.o_finish   = (r_state == DONE);
  assign bus.dbg_state  = r_state;

endmodule
